// File: rtl/headgen_stream_mux.sv
// Template-driven header byte generator: streams template entries as literal bytes
// or captured field bytes. Optional checksum logic is enabled with HEADGEN_CSUM_EN.
module headgen_stream_mux #(
    parameter int NUM_FIELDS = 4,
    parameter int TPL_DEPTH  = 16,
    parameter int LEN_W      = 5,
    localparam int AW        = $clog2(TPL_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tpl_we,
    input  logic [AW-1:0]           tpl_addr,
    input  logic [8:0]              tpl_wdata,
    input  logic [LEN_W-1:0]        tpl_len,
    input  logic [16*NUM_FIELDS-1:0] fields_in,
    input  logic                    start,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             hdr_csum
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                     r_state, w_state_nxt;
    logic [8:0]                 r_tpl [TPL_DEPTH];
    logic [NUM_FIELDS-1:0][15:0] r_fields;
    logic [LEN_W-1:0]           r_len;
    logic [AW-1:0]              r_ptr;
    logic                       r_done;

    logic [LEN_W-1:0] w_len_cap;
    logic             w_start_ok, w_fire, w_last, w_fin;
    logic [8:0]       w_ent;
    logic [15:0]      w_field;
    logic [7:0]       w_byte;

    assign w_len_cap  = (tpl_len > LEN_W'(TPL_DEPTH)) ? LEN_W'(TPL_DEPTH) : tpl_len;
    assign w_start_ok = start && (r_state == S_IDLE);
    assign w_fire     = (r_state == S_SEND) && out_ready;
    assign w_last     = (LEN_W'(r_ptr) == r_len - LEN_W'(1));
    assign w_fin      = w_fire && w_last;
    assign w_ent      = r_tpl[r_ptr];

    // Out-of-range field indices fall through to zero.
    always_comb begin
        w_field = '0;
        for (int k = 0; k < NUM_FIELDS; k++)
            if (w_ent[4:1] == 4'(k)) w_field = r_fields[k];
        w_byte = w_ent[8] ? (w_ent[0] ? w_field[7:0] : w_field[15:8]) : w_ent[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok && (w_len_cap != '0)) w_state_nxt = S_SEND;
            S_SEND: if (w_fin) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_SEND);
        busy      = (r_state == S_SEND);
        out_last  = (r_state == S_SEND) && w_last;
        out_data  = (r_state == S_SEND) ? w_byte : 8'h00;
        done      = r_done;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fields <= '0;
            r_len    <= '0;
            r_ptr    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_start_ok && (w_len_cap == '0)) || w_fin;
            if (w_start_ok) begin
                r_fields <= fields_in;
                r_len    <= w_len_cap;
                r_ptr    <= '0;
            end else if (w_fire) begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

    // Template storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (tpl_we && (r_state == S_IDLE)) r_tpl[tpl_addr] <= tpl_wdata;
    end

`ifdef HEADGEN_CSUM_EN
    logic [15:0] r_sum, r_csum;
    logic [15:0] w_addend, w_sum_nxt;
    logic [16:0] w_sum17;

    // Even byte offsets land in the high half of each 16-bit word.
    assign w_addend  = r_ptr[0] ? {8'h00, w_byte} : {w_byte, 8'h00};
    assign w_sum17   = {1'b0, r_sum} + {1'b0, w_addend};
    assign w_sum_nxt = w_sum17[15:0] + {15'b0, w_sum17[16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum  <= '0;
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
            if (w_len_cap == '0) r_csum <= 16'hFFFF;
        end else if (w_fire) begin
            r_sum <= w_sum_nxt;
            if (w_last) r_csum <= ~w_sum_nxt;
        end
    end

    assign hdr_csum = r_csum;
`else
    assign hdr_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_headgen_stream_mux.sv
// Directed bench for headgen_stream_mux: literal/field decode, stalls, zero length,
// busy-time start/write/field changes, reset abort, back-to-back headers.
module tb_headgen_stream_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        tpl_we;
    logic [3:0]  tpl_addr;
    logic [8:0]  tpl_wdata;
    logic [4:0]  tpl_len;
    logic [63:0] fields_in;
    logic        start;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] hdr_csum;

    int n_vec = 0;
    int n_err = 0;

`ifdef HEADGEN_CSUM_EN
    localparam logic [15:0] CSUM1 = 16'hEFF3;
`else
    localparam logic [15:0] CSUM1 = 16'h0000;
`endif

    headgen_stream_mux dut (
        .clk(clk), .reset(reset), .tpl_we(tpl_we), .tpl_addr(tpl_addr),
        .tpl_wdata(tpl_wdata), .tpl_len(tpl_len), .fields_in(fields_in),
        .start(start), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .done(done), .hdr_csum(hdr_csum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [8:0] d);
        tpl_we = 1'b1; tpl_addr = a; tpl_wdata = d;
        tick();
        tpl_we = 1'b0;
    endtask

    task automatic load_basic();
        wr(4'd0, 9'h001); wr(4'd1, 9'h002); wr(4'd2, 9'h003);
        wr(4'd3, 9'h100); wr(4'd4, 9'h101); wr(4'd5, 9'h102); wr(4'd6, 9'h103);
    endtask

    initial begin
        logic [7:0] exp2 [5];
        int e;
        exp2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        reset = 1'b1; tpl_we = 1'b0; tpl_addr = '0; tpl_wdata = '0; tpl_len = '0;
        fields_in = '0; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_last",  16'(out_last),  16'h0);
        chk("rst_busy",  16'(busy),      16'h0);
        chk("rst_done",  16'(done),      16'h0);
        chk("rst_data",  16'(out_data),  16'h0);
        chk("rst_csum",  hdr_csum,       16'h0);
        reset = 1'b0;
        tick();

        // Basic header; start, template write and field change while busy must be ignored
        load_basic();
        fields_in = {16'h1111, 16'h2222, 16'h0607, 16'h0405};
        tpl_len = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 7; i++) begin
            chk("t1_data",  16'(out_data),  16'(i + 1));
            chk("t1_valid", 16'(out_valid), 16'h1);
            chk("t1_last",  16'(out_last),  16'(i == 6));
            chk("t1_done",  16'(done),      16'h0);
            if (i == 2) begin start = 1'b1; fields_in = '1; end
            if (i == 3) start = 1'b0;
            if (i == 4) begin tpl_we = 1'b1; tpl_addr = 4'd0; tpl_wdata = 9'h0FF; end
            if (i == 5) tpl_we = 1'b0;
            tick();
        end
        chk("t1_done_p", 16'(done),      16'h1);
        chk("t1_idle_v", 16'(out_valid), 16'h0);
        chk("t1_idle_b", 16'(busy),      16'h0);
        chk("t1_csum",   hdr_csum,       CSUM1);

        // Back-to-back start in the done cycle, then alternate-cycle stalls
        fields_in = {16'h1111, 16'h2222, 16'h0607, 16'h0405};
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        for (int c = 0; c < 14; c++) begin
            chk("t3_data",  16'(out_data),  16'(e + 1));
            chk("t3_valid", 16'(out_valid), 16'h1);
            chk("t3_last",  16'(out_last),  16'(e == 6));
            out_ready = c[0];
            if (out_ready) e++;
            tick();
        end
        out_ready = 1'b1;
        chk("t3_done", 16'(done), 16'h1);
        chk("t3_csum", hdr_csum,  CSUM1);
        tick();
        chk("t3_done_clr", 16'(done), 16'h0);

        // Mixed literal and field bytes
        wr(4'd0, 9'h0A1); wr(4'd1, 9'h100); wr(4'd2, 9'h101);
        wr(4'd3, 9'h102); wr(4'd4, 9'h107);
        fields_in = {16'hABE5, 16'h0000, 16'hD4E5, 16'hB2C3};
        tpl_len = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_data", 16'(out_data), 16'(exp2[i]));
            chk("t2_last", 16'(out_last), 16'(i == 4));
            tick();
        end
        chk("t2_done", 16'(done), 16'h1);

        // Zero length: no byte, done next cycle
        tpl_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_valid", 16'(out_valid), 16'h0);
        chk("z_busy",  16'(busy),      16'h0);
        chk("z_done",  16'(done),      16'h1);
        tick();
        chk("z_done_clr", 16'(done), 16'h0);

        // Field index 5 beyond NUM_FIELDS decodes to zero
        wr(4'd0, 9'h10A);
        tpl_len = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("idx5_data",  16'(out_data),  16'h00);
        chk("idx5_valid", 16'(out_valid), 16'h1);
        chk("idx5_last",  16'(out_last),  16'h1);
        tick();
        chk("idx5_done", 16'(done), 16'h1);

        // Reset after third byte aborts without done
        load_basic();
        fields_in = {16'h1111, 16'h2222, 16'h0607, 16'h0405};
        tpl_len = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("ra_data4", 16'(out_data), 16'h04);
        #2 reset = 1'b1;
        #1;
        chk("ra_valid", 16'(out_valid), 16'h0);
        chk("ra_busy",  16'(busy),      16'h0);
        chk("ra_data",  16'(out_data),  16'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ra_nodone", 16'(done), 16'h0);
            tick();
        end
        load_basic();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("rb_data", 16'(out_data), 16'(i + 1));
            tick();
        end
        chk("rb_done", 16'(done),  16'h1);
        chk("rb_csum", hdr_csum,   CSUM1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
